// File: rtl/descriptor_mem_arbiter_if.sv
// Bus bundle between two Avalon-MM requesters, the arbiter and the
// single-port descriptor RAM. The arbiter connects through the slave modport;
// the requesters and the RAM connect through the master modport.
interface descriptor_mem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // port A
  logic [ADDR_W-1:0] a_address;
  logic [BE_W-1:0]   a_byteenable;
  logic              a_read;
  logic              a_write;
  logic [DATA_W-1:0] a_writedata;
  logic              a_waitrequest;
  logic [DATA_W-1:0] a_readdata;
  logic              a_readdatavalid;

  // port B
  logic [ADDR_W-1:0] b_address;
  logic [BE_W-1:0]   b_byteenable;
  logic              b_read;
  logic              b_write;
  logic [DATA_W-1:0] b_writedata;
  logic              b_waitrequest;
  logic [DATA_W-1:0] b_readdata;
  logic              b_readdatavalid;

  // RAM side
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport slave (
    input  a_address, a_byteenable, a_read, a_write, a_writedata,
    output a_waitrequest, a_readdata, a_readdatavalid,
    input  b_address, b_byteenable, b_read, b_write, b_writedata,
    output b_waitrequest, b_readdata, b_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write,
    output mem_writedata, mem_clken,
    input  mem_readdata
  );

  modport master (
    output a_address, a_byteenable, a_read, a_write, a_writedata,
    input  a_waitrequest, a_readdata, a_readdatavalid,
    output b_address, b_byteenable, b_read, b_write, b_writedata,
    input  b_waitrequest, b_readdata, b_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write,
    input  mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/descriptor_mem_arbiter.sv
// Two-port round-robin arbiter with bounded hold in front of a single-port
// descriptor RAM (registered address, 1-cycle read latency). Grant is
// combinational; read data returns one cycle after acceptance on the owner.
module descriptor_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 4
) (
  input logic                     clk,
  input logic                     reset,
  descriptor_mem_arbiter_if.slave bus
);
  localparam int             HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_MAX = HW'(MAX_HOLD);

  logic          req_a, req_b;
  logic          gnt_a, gnt_b;
  logic          keep;
  logic          acc_rd;
  logic          last_b;      // 1: last grant went to B
  logic [HW-1:0] hold_cnt;
  logic          rd_pending;
  logic          rd_owner_b;

  assign req_a = bus.a_read | bus.a_write;
  assign req_b = bus.b_read | bus.b_write;

  // Grant select: lone requester wins; on contention keep the previous owner
  // only while its run is non-zero and below the hold limit.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    keep  = (hold_cnt != '0) && (hold_cnt < HOLD_MAX);
    if (!reset) begin
      if (req_a && req_b) begin
        if (keep) begin
          gnt_a = ~last_b;
          gnt_b = last_b;
        end else begin
          gnt_a = last_b;
          gnt_b = ~last_b;
        end
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  assign bus.a_waitrequest = reset | (req_a & ~gnt_a);
  assign bus.b_waitrequest = reset | (req_b & ~gnt_b);

  // RAM pins follow the granted port; port A values sit on the bus when idle.
  assign bus.mem_address    = gnt_b ? bus.b_address    : bus.a_address;
  assign bus.mem_byteenable = gnt_b ? bus.b_byteenable : bus.a_byteenable;
  assign bus.mem_writedata  = gnt_b ? bus.b_writedata  : bus.a_writedata;
  assign bus.mem_chipselect = gnt_a | gnt_b;
  assign bus.mem_write      = (gnt_a & bus.a_write) | (gnt_b & bus.b_write);
  assign bus.mem_clken      = 1'b1;

  // Write wins over a simultaneous read, so such a cycle produces no return.
  assign acc_rd = (gnt_a & bus.a_read & ~bus.a_write) |
                  (gnt_b & bus.b_read & ~bus.b_write);

  // Read return: one-cycle valid to the owner, suppressed while in reset.
  assign bus.a_readdata      = bus.mem_readdata;
  assign bus.b_readdata      = bus.mem_readdata;
  assign bus.a_readdatavalid = ~reset & rd_pending & ~rd_owner_b;
  assign bus.b_readdatavalid = ~reset & rd_pending &  rd_owner_b;

  // Arbitration history and read-return tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_b     <= 1'b1;
      hold_cnt   <= '0;
      rd_pending <= 1'b0;
      rd_owner_b <= 1'b0;
    end else begin
      rd_pending <= acc_rd;
      rd_owner_b <= gnt_b;
      if (gnt_a | gnt_b) begin
        if (gnt_b == last_b)
          hold_cnt <= (hold_cnt < HOLD_MAX) ? hold_cnt + HW'(1) : hold_cnt;
        else
          hold_cnt <= HW'(1);
        last_b <= gnt_b;
      end else begin
        hold_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_descriptor_mem_arbiter.sv
// Directed bench for descriptor_mem_arbiter: one instance with MAX_HOLD=4
// backed by a behavioural byte-enabled RAM, one with MAX_HOLD=1 for the
// alternation case.
module tb_descriptor_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  descriptor_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus4 ();
  descriptor_mem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus1 ();

  descriptor_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_HOLD(4)) u_arb4 (
    .clk(clk), .reset(reset), .bus(bus4));
  descriptor_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_HOLD(1)) u_arb1 (
    .clk(clk), .reset(reset), .bus(bus1));

  // RAM model: registered address, unregistered output, byte-enabled writes.
  logic [31:0] ram [1024];
  logic [9:0]  ram_addr = '0;
  always @(posedge clk) begin
    if (bus4.mem_chipselect && bus4.mem_clken) begin
      if (bus4.mem_write) begin
        for (int i = 0; i < 4; i++)
          if (bus4.mem_byteenable[i])
            ram[bus4.mem_address][8*i +: 8] <= bus4.mem_writedata[8*i +: 8];
      end else begin
        ram_addr <= bus4.mem_address;
      end
    end
  end
  assign bus4.mem_readdata = ram[ram_addr];
  assign bus1.mem_readdata = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic clear();
    bus4.a_read = 0; bus4.a_write = 0; bus4.b_read = 0; bus4.b_write = 0;
    bus1.a_read = 0; bus1.a_write = 0; bus1.b_read = 0; bus1.b_write = 0;
  endtask

  logic [9:0] pat;
  logic       prev_b;

  initial begin
    clear();
    bus4.a_address = '0; bus4.a_byteenable = 4'hF; bus4.a_writedata = '0;
    bus4.b_address = '0; bus4.b_byteenable = 4'hF; bus4.b_writedata = '0;
    bus1.a_address = '0; bus1.a_byteenable = 4'hF; bus1.a_writedata = '0;
    bus1.b_address = '0; bus1.b_byteenable = 4'hF; bus1.b_writedata = '0;

    // reset held two cycles with a_read pending
    bus4.a_read = 1;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("rst_a_wait", bus4.a_waitrequest, 1);
      chk("rst_b_wait", bus4.b_waitrequest, 1);
      chk("rst_cs", bus4.mem_chipselect, 0);
      chk("rst_a_rdv", bus4.a_readdatavalid, 0);
      chk("rst_b_rdv", bus4.b_readdatavalid, 0);
      step();
    end
    reset = 0;
    smp();
    chk("post_rst_a_wait", bus4.a_waitrequest, 0);
    chk("post_rst_cs", bus4.mem_chipselect, 1);
    chk("post_rst_we", bus4.mem_write, 0);
    step();
    bus4.a_read = 0;
    smp();
    chk("post_rst_a_rdv", bus4.a_readdatavalid, 1);
    chk("post_rst_b_rdv", bus4.b_readdatavalid, 0);
    step();

    // A full write, B byte-lane-0 write, A read back
    bus4.a_write = 1; bus4.a_address = 10'h005; bus4.a_byteenable = 4'hF;
    bus4.a_writedata = 32'hDEADBEEF;
    smp();
    chk("wa_wait", bus4.a_waitrequest, 0);
    chk("wa_idle_b_wait", bus4.b_waitrequest, 0);
    chk("wa_we", bus4.mem_write, 1);
    chk("wa_addr", 32'(bus4.mem_address), 32'h005);
    chk("wa_wdata", bus4.mem_writedata, 32'hDEADBEEF);
    step();
    bus4.a_write = 0;
    bus4.b_write = 1; bus4.b_address = 10'h005; bus4.b_byteenable = 4'h1;
    bus4.b_writedata = 32'h000000AA;
    smp();
    chk("wb_wait", bus4.b_waitrequest, 0);
    chk("wb_be", 32'(bus4.mem_byteenable), 32'h1);
    chk("wb_wdata", bus4.mem_writedata, 32'h000000AA);
    step();
    bus4.b_write = 0;
    bus4.a_read = 1;
    smp();
    chk("ra_wait", bus4.a_waitrequest, 0);
    chk("ra_we", bus4.mem_write, 0);
    step();
    bus4.a_read = 0;
    smp();
    chk("ra_rdv", bus4.a_readdatavalid, 1);
    chk("ra_data", bus4.a_readdata, 32'hDEADBEAA);
    chk("ra_b_rdv", bus4.b_readdatavalid, 0);
    step();
    smp();
    chk("ra_rdv_once", bus4.a_readdatavalid, 0);
    chk("idle_cs", bus4.mem_chipselect, 0);
    chk("idle_addr", 32'(bus4.mem_address), 32'h005);
    step();

    // read+write together: write wins, no read return
    bus4.a_read = 1; bus4.a_write = 1; bus4.a_address = 10'h010;
    bus4.a_byteenable = 4'hF; bus4.a_writedata = 32'h12345678;
    smp();
    chk("rw_we", bus4.mem_write, 1);
    step();
    bus4.a_write = 0; bus4.a_read = 0;
    smp();
    chk("rw_no_rdv", bus4.a_readdatavalid, 0);
    step();
    bus4.a_read = 1;
    smp();
    chk("rw_rd_wait", bus4.a_waitrequest, 0);
    step();
    bus4.a_read = 0;
    smp();
    chk("rw_rd_rdv", bus4.a_readdatavalid, 1);
    chk("rw_rd_data", bus4.a_readdata, 32'h12345678);
    step();

    // round robin, MAX_HOLD=4: A alone three times, then both continuous
    reset = 1;
    step();
    reset = 0;
    bus4.a_read = 1; bus4.a_address = 10'h001;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("rr_solo_a_wait", bus4.a_waitrequest, 0);
      step();
    end
    bus4.b_read = 1; bus4.b_address = 10'h002;
    pat = 10'b10_0001_1110;  // bit i = 1 when B owns cycle i
    prev_b = 0;
    for (int i = 0; i < 10; i++) begin
      smp();
      chk("rr_a_wait", bus4.a_waitrequest, 32'(pat[i]));
      chk("rr_b_wait", bus4.b_waitrequest, 32'(!pat[i]));
      chk("rr_addr", 32'(bus4.mem_address), pat[i] ? 32'h002 : 32'h001);
      chk("rr_a_rdv", bus4.a_readdatavalid, 32'(!prev_b));
      chk("rr_b_rdv", bus4.b_readdatavalid, 32'(prev_b));
      prev_b = pat[i];
      step();
    end
    clear();
    smp();
    chk("rr_tail_a_rdv", bus4.a_readdatavalid, 0);
    chk("rr_tail_b_rdv", bus4.b_readdatavalid, 1);
    step();

    // MAX_HOLD=1: strict alternation, then idle, then other-than-last wins
    bus1.a_read = 1; bus1.b_read = 1;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("mh1_a_wait", bus1.a_waitrequest, (i == 1) ? 32'd1 : 32'd0);
      chk("mh1_b_wait", bus1.b_waitrequest, (i == 1) ? 32'd0 : 32'd1);
      step();
    end
    clear();
    smp();
    chk("mh1_idle_cs", bus1.mem_chipselect, 0);
    step();
    bus1.a_read = 1; bus1.b_read = 1;
    smp();
    chk("mh1_resume_a_wait", bus1.a_waitrequest, 1);
    chk("mh1_resume_b_wait", bus1.b_waitrequest, 0);
    step();
    clear();

    // reset lands the cycle after a read is accepted
    bus4.a_read = 1; bus4.a_address = 10'h005;
    smp();
    chk("mr_acc", bus4.a_waitrequest, 0);
    step();
    bus4.a_read = 0;
    reset = 1;
    smp();
    chk("mr_a_rdv", bus4.a_readdatavalid, 0);
    chk("mr_b_rdv", bus4.b_readdatavalid, 0);
    chk("mr_cs", bus4.mem_chipselect, 0);
    chk("mr_b_wait", bus4.b_waitrequest, 1);
    step();
    reset = 0;
    smp();
    chk("mr_after_a_rdv", bus4.a_readdatavalid, 0);
    step();
    bus4.a_read = 1; bus4.b_read = 1;
    smp();
    chk("mr_first_a_wait", bus4.a_waitrequest, 0);
    chk("mr_first_b_wait", bus4.b_waitrequest, 1);
    step();
    clear();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/descriptor_mem_arbiter.md
Name: descriptor_mem_arbiter

Overview:
Two-requester arbiter that shares one single-port 1024x32 descriptor RAM (byte-enabled, address registered, output unregistered, 1-cycle read latency) between two Avalon-MM masters, typically the SG-DMA descriptor fetch/writeback master (port A) and the Nios II data master (port B). It selects one request per cycle with round-robin and bounded hold, drives the RAM control pins, and returns read data with a per-port readdatavalid pulse. It sits between the system interconnect and the descriptor RAM instance.

Parameters:
ADDR_W, 10, word address width (1024 words)
DATA_W, 32, data width; byteenable width is DATA_W/8
MAX_HOLD, 4, max consecutive grants to one port while the other port is requesting (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
a_address  input  ADDR_W  port A word address
a_byteenable  input  DATA_W/8  port A byte lanes
a_read  input  1  port A read request
a_write  input  1  port A write request
a_writedata  input  DATA_W  port A write data
a_waitrequest  output  1  port A stall; request not accepted this cycle
a_readdata  output  DATA_W  port A read data
a_readdatavalid  output  1  port A read data valid
b_* (address, byteenable, read, write, writedata, waitrequest, readdata, readdatavalid)  same as A  port B
mem_address  output  ADDR_W  RAM address
mem_byteenable  output  DATA_W/8  RAM byte enables
mem_chipselect  output  1  RAM select
mem_write  output  1  RAM write
mem_writedata  output  DATA_W  RAM write data
mem_clken  output  1  RAM clock enable, tied 1
mem_readdata  input  DATA_W  RAM read data, valid the cycle after a read is accepted

Behaviour:
- Clock is clk; reset is synchronous and active-high. During reset: both waitrequests=1, mem_chipselect=0, mem_write=0, both readdatavalid=0, last_grant=B, hold_cnt=0, rd_pending=0.
- req_X = X_read | X_write. If read and write are both asserted, write wins; no readdatavalid results.
- Grant is combinational in the same cycle. One requester -> it wins. Both requesting -> keep last_grant if 0 < hold_cnt < MAX_HOLD, else grant the port other than last_grant.
- X_waitrequest = reset | (req_X & ~grant_X). Idle port waitrequest=0. Acceptance = req & ~waitrequest.
- mem_* are muxed from the granted port. mem_chipselect = any grant. mem_write = granted port's write. With no grant, mem_address/byteenable/writedata hold port A values and mem_chipselect=0.
- hold_cnt (clog2(MAX_HOLD+1) bits) updates on each grant to X: X==last_grant -> saturating increment to MAX_HOLD; otherwise set to 1. Then last_grant<=X. A cycle with no grant clears hold_cnt to 0 and leaves last_grant unchanged.
- Read return: an accepted read sets rd_pending=1 and rd_owner=X for the next cycle. In that cycle X_readdatavalid=1 and both X_readdata = mem_readdata. Back-to-back reads from either port are accepted every cycle (fully pipelined, 1 cycle latency, no bubbles).
- Writes complete on acceptance; no response.
- Reset mid-read: rd_pending is cleared and no readdatavalid is emitted after reset.
- Port A address out of range is impossible (ADDR_W = RAM depth); no error response.

Test Plan:
- Reset: assert reset 2 cycles with a_read=1 -> a/b_waitrequest=1, mem_chipselect=0, no readdatavalid; first cycle after deassert, A is granted (last_grant=B at reset).
- A writes 0xDEADBEEF to addr 0x005 with byteenable 0xF, then B writes byteenable 0x1 data 0x000000AA to 0x005; A reads 0x005 -> a_readdatavalid exactly 1 cycle after acceptance, a_readdata=0xDEADBEAA, b_readdatavalid=0.
- Both ports issue continuous reads, MAX_HOLD=4 -> grant pattern A,B,B,B,B,A,A,A,A,B... (first switch after reset); each port's waitrequest drops at most 4 consecutive cycles of the other's grant; every accepted read yields exactly one readdatavalid on the correct port.
- MAX_HOLD=1, both requesting -> strict alternation A,B,A,B; an idle cycle (no requests) then both request -> port other than last_grant wins.
- Read accepted at cycle N, reset asserted at N+1 -> no readdatavalid at N+1 or later; state returns to reset values.
- a_read=a_write=1 on addr 0x010 data 0x12345678 -> RAM written, no a_readdatavalid; subsequent read of 0x010 returns 0x12345678.
